// File: rtl/fft4_out_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fft4_out_serializer
//  Purpose  : Captures the four complex results of the 4-point FFT core on the
//             rising edge of fft_done and streams them out over valid/ready.
//             Optional build macro FFT4_SER_ROUND_EN: halve with round-half-up
//             and saturate each value to N bits at capture.
//  Revision : 1.0  initial release
// ============================================================================
module fft4_out_serializer #(
   parameter int N = 18,
`ifdef FFT4_SER_ROUND_EN
   localparam int OW = N
`else
   localparam int OW = N + 1
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fft_done,
   input  logic signed [N:0]    in0_r,
   input  logic signed [N:0]    in0_i,
   input  logic signed [N:0]    in1_r,
   input  logic signed [N:0]    in1_i,
   input  logic signed [N:0]    in2_r,
   input  logic signed [N:0]    in2_i,
   input  logic signed [N:0]    in3_r,
   input  logic signed [N:0]    in3_i,
   output logic signed [OW-1:0] dout_r,
   output logic signed [OW-1:0] dout_i,
   output logic [1:0]           dout_idx,
   output logic                 dout_valid,
   output logic                 dout_last,
   input  logic                 dout_ready,
   output logic                 frame_ack,
   output logic                 busy,
   output logic                 overrun
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [1:0]            r_idx, w_idx_nxt, w_idx_inc;
   logic                  r_done_d;
   logic                  w_rise, w_capture;
   logic signed [OW-1:0]  r_buf_r [4];
   logic signed [OW-1:0]  r_buf_i [4];
   logic signed [OW-1:0]  w_cap_r [4];
   logic signed [OW-1:0]  w_cap_i [4];
   logic signed [OW-1:0]  w_dr_nxt, w_di_nxt;
   logic                  w_valid_nxt, w_last_nxt, w_ack_nxt, w_busy_nxt, w_ovr_nxt;

   function automatic logic signed [OW-1:0] conv(input logic signed [N:0] x);
`ifdef FFT4_SER_ROUND_EN
      logic signed [N+1:0] s;
      s = {x[N], x} + {{(N+1){1'b0}}, 1'b1};
      s = s >>> 1;
      // Only the positive end can leave the N-bit range after halving
      if (s > $signed({3'b000, {(N-1){1'b1}}}))
         return {1'b0, {(N-1){1'b1}}};
      else if (s < $signed({3'b111, {(N-1){1'b0}}}))
         return {1'b1, {(N-1){1'b0}}};
      else
         return s[N-1:0];
`else
      return x;
`endif
   endfunction

   always_comb begin
      w_cap_r[0] = conv(in0_r);
      w_cap_i[0] = conv(in0_i);
      w_cap_r[1] = conv(in1_r);
      w_cap_i[1] = conv(in1_i);
      w_cap_r[2] = conv(in2_r);
      w_cap_i[2] = conv(in2_i);
      w_cap_r[3] = conv(in3_r);
      w_cap_i[3] = conv(in3_i);
   end

   assign w_rise    = fft_done & ~r_done_d;
   assign w_idx_inc = r_idx + 2'd1;
   assign dout_idx  = r_idx;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      w_dr_nxt    = dout_r;
      w_di_nxt    = dout_i;
      w_valid_nxt = dout_valid;
      w_last_nxt  = dout_last;
      w_ack_nxt   = 1'b0;
      w_busy_nxt  = busy;
      w_ovr_nxt   = overrun;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_capture   = 1'b1;
               w_state_nxt = S_STREAM;
               w_idx_nxt   = 2'd0;
               w_dr_nxt    = w_cap_r[0];
               w_di_nxt    = w_cap_i[0];
               w_valid_nxt = 1'b1;
               w_last_nxt  = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         S_STREAM: begin
            if (w_rise)
               w_ovr_nxt = 1'b1;
            if (dout_ready) begin
               if (r_idx == 2'd3) begin
                  w_state_nxt = S_ACK;
                  w_idx_nxt   = 2'd0;
                  w_dr_nxt    = '0;
                  w_di_nxt    = '0;
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_ack_nxt   = 1'b1;
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_dr_nxt    = r_buf_r[w_idx_inc];
                  w_di_nxt    = r_buf_i[w_idx_inc];
                  w_last_nxt  = (w_idx_inc == 2'd3);
               end
            end
         end
         S_ACK: begin
            // A rise landing on the ACK->IDLE edge is still treated as overrun
            if (w_rise)
               w_ovr_nxt = 1'b1;
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= 2'd0;
         r_done_d   <= 1'b1;
         dout_r     <= '0;
         dout_i     <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         frame_ack  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idx      <= w_idx_nxt;
         r_done_d   <= fft_done;
         dout_r     <= w_dr_nxt;
         dout_i     <= w_di_nxt;
         dout_valid <= w_valid_nxt;
         dout_last  <= w_last_nxt;
         frame_ack  <= w_ack_nxt;
         busy       <= w_busy_nxt;
         overrun    <= w_ovr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int k = 0; k < 4; k++) begin
            r_buf_r[k] <= w_cap_r[k];
            r_buf_i[k] <= w_cap_i[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fft4_out_serializer.sv
`default_nettype none
// Bench for fft4_out_serializer: queue-based frame model checked every cycle,
// plus directed literal checks of the worked examples.
module tb_fft4_out_serializer;
   localparam int N = 18;
`ifdef FFT4_SER_ROUND_EN
   localparam int OW = N;
`else
   localparam int OW = N + 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 fft_done = 1'b0;
   logic                 dout_ready = 1'b0;
   logic signed [N:0]    in0_r = '0, in0_i = '0, in1_r = '0, in1_i = '0;
   logic signed [N:0]    in2_r = '0, in2_i = '0, in3_r = '0, in3_i = '0;
   logic signed [OW-1:0] dout_r, dout_i;
   logic [1:0]           dout_idx;
   logic                 dout_valid, dout_last, frame_ack, busy, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   fft4_out_serializer #(.N(N)) dut (
      .clk(clk), .rst(rst), .fft_done(fft_done),
      .in0_r(in0_r), .in0_i(in0_i), .in1_r(in1_r), .in1_i(in1_i),
      .in2_r(in2_r), .in2_i(in2_i), .in3_r(in3_r), .in3_i(in3_i),
      .dout_r(dout_r), .dout_i(dout_i), .dout_idx(dout_idx),
      .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
      .frame_ack(frame_ack), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Value a captured sample must stream as, from the arithmetic rule directly
   function automatic int scale(input int x);
`ifdef FFT4_SER_ROUND_EN
      int y;
      y = (x + 1) >>> 1;
      if (y > (1 << (N - 1)) - 1) y = (1 << (N - 1)) - 1;
      if (y < -(1 << (N - 1)))    y = -(1 << (N - 1));
      return y;
`else
      return x;
`endif
   endfunction

   typedef struct {
      int r;
      int i;
      int idx;
   } beat_t;

   beat_t q[$];
   bit    m_ack  = 1'b0;
   bit    m_prev = 1'b1;
   bit    m_ovr  = 1'b0;
   bit    m_rst_seen;

   // Model: a frame is four beats waiting in a queue, followed by one ack cycle
   always @(posedge clk) begin
      bit rise;
      m_rst_seen = rst;
      if (rst) begin
         q.delete();
         m_ack  = 1'b0;
         m_prev = 1'b1;
         m_ovr  = 1'b0;
      end else begin
         rise = fft_done && !m_prev;
         if (m_ack) begin
            m_ack = 1'b0;
            if (rise) m_ovr = 1'b1;
         end else if (q.size() > 0) begin
            if (rise) m_ovr = 1'b1;
            if (dout_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) m_ack = 1'b1;
            end
         end else if (rise) begin
            q.push_back('{scale(int'(in0_r)), scale(int'(in0_i)), 0});
            q.push_back('{scale(int'(in1_r)), scale(int'(in1_i)), 1});
            q.push_back('{scale(int'(in2_r)), scale(int'(in2_i)), 2});
            q.push_back('{scale(int'(in3_r)), scale(int'(in3_i)), 3});
         end
         m_prev = fft_done;
      end
      #1;
      chk("valid", int'(dout_valid), int'(q.size() > 0));
      chk("frame_ack", int'(frame_ack), int'(m_ack));
      chk("busy", int'(busy), int'((q.size() > 0) || m_ack));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (q.size() > 0) begin
         chk("dout_r", int'(dout_r), q[0].r);
         chk("dout_i", int'(dout_i), q[0].i);
         chk("dout_idx", int'(dout_idx), q[0].idx);
         chk("dout_last", int'(dout_last), int'(q[0].idx == 3));
      end
      if (m_rst_seen) begin
         chk("rst_dout_r", int'(dout_r), 0);
         chk("rst_dout_i", int'(dout_i), 0);
         chk("rst_idx", int'(dout_idx), 0);
         chk("rst_last", int'(dout_last), 0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_frame(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int h);
      in0_r = a[N:0]; in0_i = b[N:0]; in1_r = c[N:0]; in1_i = d[N:0];
      in2_r = e[N:0]; in2_i = f[N:0]; in3_r = g[N:0]; in3_i = h[N:0];
   endtask

   task automatic wait_ack(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         if (frame_ack) seen = 1'b1;
      end
      chk({name, "_ack_timeout"}, int'(seen), 1);
   endtask

   int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
`ifdef FFT4_SER_ROUND_EN
   int lit_b0r = 50,  lit_b0i = -2;
   int lit_r0r = 2,   lit_r0i = -1, lit_r1r = 131071, lit_r1i = -131072;
`else
   int lit_b0r = 100, lit_b0i = -5;
   int lit_r0r = 3,   lit_r0i = -3, lit_r1r = 262143, lit_r1i = -262144;
`endif

   initial begin
      tick(); tick();
      rst = 1'b0;

      // Basic frame
      tick(); tick();
      set_frame(100, -5, 3, 7, -8, 0, 1, -1);
      fft_done = 1'b1; dout_ready = 1'b1;
      tick();
      chk("basic_b0_valid", int'(dout_valid), 1);
      chk("basic_b0_r", int'(dout_r), lit_b0r);
      chk("basic_b0_i", int'(dout_i), lit_b0i);
      wait_ack("basic");
      fft_done = 1'b0;
      tick(); tick();
      chk("basic_busy_after", int'(busy), 0);

      // Backpressure
      fft_done = 1'b1;
      for (int k = 0; k < 7; k++) begin
         dout_ready = pat[k][0];
         tick();
      end
      dout_ready = 1'b1;
      wait_ack("bp");
      fft_done = 1'b0;
      tick(); tick();

      // Overrun
      dout_ready = 1'b0;
      fft_done = 1'b1;
      tick(); tick();
      fft_done = 1'b0;
      tick();
      set_frame(11, 12, 13, 14, 15, 16, 17, 18);
      fft_done = 1'b1;
      tick();
      chk("ovr_set", int'(overrun), 1);
      chk("ovr_hold_r", int'(dout_r), lit_b0r);
      dout_ready = 1'b1;
      wait_ack("ovr");
      fft_done = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("ovr_sticky", int'(overrun), 1);
      chk("ovr_no_second", int'(dout_valid), 0);

      // Reset mid-stream, with done held high across the reset
      set_frame(-1, 2, -3, 4, -5, 6, -7, 8);
      fft_done = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_ack", int'(frame_ack), 0);
      chk("rst_ovr", int'(overrun), 0);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rst_no_capture", int'(dout_valid), 0);
      fft_done = 1'b0;
      tick();
      set_frame(21, -22, 23, -24, 25, -26, 27, -28);
      fft_done = 1'b1;
      tick();
      chk("rearm_valid", int'(dout_valid), 1);

      // Two frames back to back: drop done on ack, raise 3 cycles later
      wait_ack("frame1");
      fft_done = 1'b0;
      tick(); tick(); tick();
      set_frame(-100, 100, 200, -200, 300, -300, 400, -400);
      fft_done = 1'b1;
      tick();
      chk("frame2_idx0", int'(dout_idx), 0);
      wait_ack("frame2");
      fft_done = 1'b0;
      tick(); tick();

      // Rounding vectors (pass-through in default build)
      set_frame(3, -3, 262143, -262144, -1, 1, 0, 0);
      fft_done = 1'b1;
      tick();
      chk("rnd_b0_r", int'(dout_r), lit_r0r);
      chk("rnd_b0_i", int'(dout_i), lit_r0i);
      tick();
      chk("rnd_b1_r", int'(dout_r), lit_r1r);
      chk("rnd_b1_i", int'(dout_i), lit_r1i);
      wait_ack("rnd");
      fft_done = 1'b0;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
